issue_queue: RTL and testbench

Instruction queue between fetch and the dual-issue dependency-check stage. Fetch pushes up to two instructions per cycle. The check stage consumes 0, 1 or 2 instructions per cycle, depending on hazards and stalls. The queue decouples fetch bandwidth from issue rate, presents the two oldest entries as the issue pair, and empties on branch mispredict.

---
 rtl/issue_queue.sv | 120 ++++++++++++
 tb/tb_issue_queue.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue.sv
// Instruction queue between fetch and the dual-issue check stage.
// Circular buffer that accepts up to two pushes and two pops per cycle and presents the two oldest entries.
module issue_queue #(
    parameter int DEPTH = 8
) (
    input  logic                       CLK,
    input  logic                       NRST,
    input  logic [1:0]                 push_valid,
    input  logic [12:0]                pc0_in,
    input  logic [12:0]                pc1_in,
    input  logic [31:0]                inst0_in,
    input  logic [31:0]                inst1_in,
    input  logic [1:0]                 state0_in,
    input  logic [1:0]                 state1_in,
    output logic                       fetch_ready,
    input  logic [1:0]                 pop,
    input  logic                       stall,
    input  logic                       flush,
    output logic [12:0]                pc1_out,
    output logic [12:0]                pc2_out,
    output logic [31:0]                inst1_out,
    output logic [31:0]                inst2_out,
    output logic [1:0]                 state1_out,
    output logic [1:0]                 state2_out,
    output logic [1:0]                 valid_out,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [12:0] pc;
        logic [31:0] inst;
        logic [1:0]  state;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [CW-1:0]   head_q, head_d;
    logic [CW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [1:0]      push_n, pop_req, pop_n;
    logic [AW-1:0]   wr_idx0, wr_idx1, rd_idx0, rd_idx1;
    entry_t          slot0, slot1, entry1, entry2;
    logic            entry1_present, entry2_present;

    assign slot0 = {pc0_in, inst0_in, state0_in};
    assign slot1 = {pc1_in, inst1_in, state1_in};

    // Decoded from the registered count so a full two-entry push always fits.
    assign fetch_ready = (count_q <= CW'(DEPTH - 2));

    always_comb begin
        push_n = 2'd0;
        case (push_valid)
            2'b01:   push_n = 2'd1;
            2'b11:   push_n = 2'd2;
            default: push_n = 2'd0;
        endcase
        if (!fetch_ready) push_n = 2'd0;

        pop_req = (pop == 2'd3) ? 2'd2 : pop;
        pop_n   = pop_req;
        if (CW'(pop_req) > count_q) pop_n = count_q[1:0];
        if (stall) pop_n = 2'd0;

        head_d  = head_q + CW'(pop_n);
        tail_d  = tail_q + CW'(push_n);
        count_d = count_q + CW'(push_n) - CW'(pop_n);

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign wr_idx0 = tail_q[AW-1:0];
    assign wr_idx1 = wr_idx0 + AW'(1);

    // NOTE: storage has no reset; stale contents are masked by count, keeping the array a plain RAM.
    always_ff @(posedge CLK) begin
        if (!flush) begin
            if (push_n != 2'd0) mem_q[wr_idx0] <= slot0;
            if (push_n == 2'd2) mem_q[wr_idx1] <= slot1;
        end
    end

    assign rd_idx0        = head_q[AW-1:0];
    assign rd_idx1        = rd_idx0 + AW'(1);
    assign entry1_present = (count_q >= CW'(1));
    assign entry2_present = (count_q >= CW'(2));

    // Absent entries read as zero, which downstream treats as a bubble.
    assign entry1 = entry1_present ? mem_q[rd_idx0] : '0;
    assign entry2 = entry2_present ? mem_q[rd_idx1] : '0;

    assign pc1_out    = entry1.pc;
    assign inst1_out  = entry1.inst;
    assign state1_out = entry1.state;
    assign pc2_out    = entry2.pc;
    assign inst2_out  = entry2.inst;
    assign state2_out = entry2.state;
    assign valid_out  = {entry2_present, entry1_present};
    assign count      = count_q;

endmodule

// File: tb/tb_issue_queue.sv
// Directed self-checking bench for issue_queue (DEPTH=8).
// Inputs change and outputs are sampled on the falling edge, away from the active edge.
module tb_issue_queue;

    logic        CLK;
    logic        NRST;
    logic [1:0]  push_valid;
    logic [12:0] pc0_in, pc1_in;
    logic [31:0] inst0_in, inst1_in;
    logic [1:0]  state0_in, state1_in;
    logic        fetch_ready;
    logic [1:0]  pop;
    logic        stall;
    logic        flush;
    logic [12:0] pc1_out, pc2_out;
    logic [31:0] inst1_out, inst2_out;
    logic [1:0]  state1_out, state2_out;
    logic [1:0]  valid_out;
    logic [3:0]  count;

    int errors = 0;
    int checks = 0;

    issue_queue #(.DEPTH(8)) dut (
        .CLK        (CLK),
        .NRST       (NRST),
        .push_valid (push_valid),
        .pc0_in     (pc0_in),
        .pc1_in     (pc1_in),
        .inst0_in   (inst0_in),
        .inst1_in   (inst1_in),
        .state0_in  (state0_in),
        .state1_in  (state1_in),
        .fetch_ready(fetch_ready),
        .pop        (pop),
        .stall      (stall),
        .flush      (flush),
        .pc1_out    (pc1_out),
        .pc2_out    (pc2_out),
        .inst1_out  (inst1_out),
        .inst2_out  (inst2_out),
        .state1_out (state1_out),
        .state2_out (state2_out),
        .valid_out  (valid_out),
        .count      (count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        push_valid = 2'b00;
        pc0_in = '0; pc1_in = '0;
        inst0_in = '0; inst1_in = '0;
        state0_in = '0; state1_in = '0;
        pop = 2'd0; stall = 1'b0; flush = 1'b0;
    endtask

    task automatic set_push(input logic [1:0] v, input logic [12:0] p0, input logic [31:0] i0,
                            input logic [12:0] p1, input logic [31:0] i1);
        push_valid = v;
        pc0_in = p0; inst0_in = i0; state0_in = i0[1:0];
        pc1_in = p1; inst1_in = i1; state1_in = i1[1:0];
    endtask

    task automatic do_flush();
        idle_inputs();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (count !== 4'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count); end
    endtask

    task automatic test_reset();
        idle_inputs();
        NRST = 1'b1;
        #12;
        NRST = 1'b0;
        #1;
        checks++;
        if (valid_out !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b expected 00", valid_out); end
        checks++;
        if (inst1_out !== 32'd0 || inst2_out !== 32'd0) begin
            errors++; $display("FAIL reset_inst: got %h/%h expected 0/0", inst1_out, inst2_out);
        end
        checks++;
        if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++;
        if (fetch_ready !== 1'b1) begin errors++; $display("FAIL reset_fetch_ready: got %b expected 1", fetch_ready); end
        @(negedge CLK);
        NRST = 1'b1;
        tick();
    endtask

    task automatic test_push_pop();
        set_push(2'b11, 13'h004, 32'h0050_0093, 13'h008, 32'h0010_8113);
        tick();
        idle_inputs();
        checks++;
        if (valid_out !== 2'b11) begin errors++; $display("FAIL pp_valid: got %b expected 11", valid_out); end
        checks++;
        if (inst1_out !== 32'h0050_0093) begin errors++; $display("FAIL pp_inst1: got %h expected 00500093", inst1_out); end
        checks++;
        if (inst2_out !== 32'h0010_8113 || pc2_out !== 13'h008) begin
            errors++; $display("FAIL pp_entry2: got %h/%h expected 00108113/0008", inst2_out, pc2_out);
        end
        checks++;
        if (pc1_out !== 13'h004 || state1_out !== 2'b11) begin
            errors++; $display("FAIL pp_entry1: got pc %h state %b expected 0004/11", pc1_out, state1_out);
        end
        checks++;
        if (count !== 4'd2) begin errors++; $display("FAIL pp_count: got %0d expected 2", count); end
        pop = 2'd1;
        tick();
        idle_inputs();
        checks++;
        if (inst1_out !== 32'h0010_8113) begin errors++; $display("FAIL pop1_inst1: got %h expected 00108113", inst1_out); end
        checks++;
        if (valid_out !== 2'b01) begin errors++; $display("FAIL pop1_valid: got %b expected 01", valid_out); end
        checks++;
        if (inst2_out !== 32'd0 || pc2_out !== 13'd0 || state2_out !== 2'd0) begin
            errors++; $display("FAIL pop1_bubble: got %h/%h/%b expected zero", inst2_out, pc2_out, state2_out);
        end
        checks++;
        if (count !== 4'd1) begin errors++; $display("FAIL pop1_count: got %0d expected 1", count); end
        do_flush();
    endtask

    task automatic test_fill();
        for (int k = 0; k < 4; k++) begin
            set_push(2'b11, 13'(2*k), 32'hA000_0000 + 32'(2*k), 13'(2*k+1), 32'hA000_0000 + 32'(2*k+1));
            tick();
            checks++;
            if (count !== 4'(2*k+2)) begin errors++; $display("FAIL fill_count%0d: got %0d expected %0d", k, count, 2*k+2); end
            checks++;
            if (fetch_ready !== (k < 3)) begin
                errors++; $display("FAIL fill_ready%0d: got %b expected %b", k, fetch_ready, (k < 3));
            end
        end
        set_push(2'b11, 13'h1F0, 32'hDEAD_0000, 13'h1F1, 32'hDEAD_0001);
        tick();
        checks++;
        if (count !== 4'd8) begin errors++; $display("FAIL full_drop_count: got %0d expected 8", count); end
        pop = 2'd2;
        tick();
        checks++;
        if (count !== 4'd6) begin errors++; $display("FAIL full_pop_count: got %0d expected 6", count); end
        checks++;
        if (fetch_ready !== 1'b1) begin errors++; $display("FAIL full_pop_ready: got %b expected 1", fetch_ready); end
        checks++;
        if (inst1_out !== 32'hA000_0002 || inst2_out !== 32'hA000_0003) begin
            errors++; $display("FAIL full_pop_order: got %h/%h expected A0000002/A0000003", inst1_out, inst2_out);
        end
        idle_inputs();
        tick();
        checks++;
        if (count !== 4'd6 || inst1_out !== 32'hA000_0002) begin
            errors++; $display("FAIL full_no_drop_leak: got count %0d inst %h expected 6/A0000002", count, inst1_out);
        end
        do_flush();
    endtask

    task automatic test_wrap();
        for (int c = 0; c < 20; c++) begin
            set_push(2'b11, 13'(2*c), 32'hB000_0000 + 32'(2*c), 13'(2*c+1), 32'hB000_0000 + 32'(2*c+1));
            pop = 2'd2;
            tick();
            checks++;
            if (count !== 4'd2) begin errors++; $display("FAIL wrap_count%0d: got %0d expected 2", c, count); end
            checks++;
            if (pc1_out !== 13'(2*c) || inst1_out !== 32'hB000_0000 + 32'(2*c)) begin
                errors++; $display("FAIL wrap_entry1_%0d: got %h/%h expected %h", c, pc1_out, inst1_out, 32'hB000_0000 + 32'(2*c));
            end
            checks++;
            if (pc2_out !== 13'(2*c+1) || inst2_out !== 32'hB000_0000 + 32'(2*c+1)) begin
                errors++; $display("FAIL wrap_entry2_%0d: got %h/%h expected %h", c, pc2_out, inst2_out, 32'hB000_0000 + 32'(2*c+1));
            end
        end
        do_flush();
    endtask

    task automatic test_simultaneous();
        set_push(2'b11, 13'h100, 32'hC000_0000, 13'h101, 32'hC000_0001);
        tick();
        set_push(2'b11, 13'h102, 32'hC000_0002, 13'h103, 32'hC000_0003);
        tick();
        set_push(2'b01, 13'h104, 32'hC000_0004, 13'h1FF, 32'hFFFF_FFFF);
        tick();
        checks++;
        if (count !== 4'd5) begin errors++; $display("FAIL sim_setup_count: got %0d expected 5", count); end
        set_push(2'b11, 13'h105, 32'hC000_0005, 13'h106, 32'hC000_0006);
        pop = 2'd2; stall = 1'b1;
        tick();
        checks++;
        if (count !== 4'd7) begin errors++; $display("FAIL sim_stall_count: got %0d expected 7", count); end
        checks++;
        if (inst1_out !== 32'hC000_0000 || inst2_out !== 32'hC000_0001) begin
            errors++; $display("FAIL sim_stall_head: got %h/%h expected C0000000/C0000001", inst1_out, inst2_out);
        end
        checks++;
        if (fetch_ready !== 1'b0) begin errors++; $display("FAIL sim_count7_ready: got %b expected 0", fetch_ready); end
        set_push(2'b11, 13'h107, 32'hC000_0007, 13'h108, 32'hC000_0008);
        pop = 2'd1; stall = 1'b0; flush = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (count !== 4'd0 || valid_out !== 2'b00) begin
            errors++; $display("FAIL sim_flush: got count %0d valid %b expected 0/00", count, valid_out);
        end
        checks++;
        if (inst1_out !== 32'd0 || fetch_ready !== 1'b1) begin
            errors++; $display("FAIL sim_flush_out: got inst %h ready %b expected 0/1", inst1_out, fetch_ready);
        end
    endtask

    task automatic test_clip();
        set_push(2'b01, 13'h200, 32'hD000_0000, 13'h000, 32'h0);
        tick();
        idle_inputs();
        pop = 2'd2;
        tick();
        checks++;
        if (count !== 4'd0 || valid_out !== 2'b00) begin
            errors++; $display("FAIL clip_count: got count %0d valid %b expected 0/00", count, valid_out);
        end
        set_push(2'b11, 13'h201, 32'hD000_0001, 13'h202, 32'hD000_0002);
        pop = 2'd0;
        tick();
        idle_inputs();
        checks++;
        if (inst1_out !== 32'hD000_0001 || inst2_out !== 32'hD000_0002 || count !== 4'd2) begin
            errors++; $display("FAIL clip_order: got %h/%h count %0d expected D0000001/D0000002/2", inst1_out, inst2_out, count);
        end
        pop = 2'd3;
        tick();
        checks++;
        if (count !== 4'd0) begin errors++; $display("FAIL pop3_count: got %0d expected 0", count); end
        pop = 2'd2;
        tick();
        checks++;
        if (count !== 4'd0 || inst1_out !== 32'd0 || inst2_out !== 32'd0) begin
            errors++; $display("FAIL empty_pop: got count %0d inst %h/%h expected 0/0/0", count, inst1_out, inst2_out);
        end
        set_push(2'b10, 13'h300, 32'hE000_0000, 13'h301, 32'hE000_0001);
        pop = 2'd0;
        tick();
        idle_inputs();
        checks++;
        if (count !== 4'd0 || valid_out !== 2'b00) begin
            errors++; $display("FAIL push10_ignored: got count %0d valid %b expected 0/00", count, valid_out);
        end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_fill();
        test_wrap();
        test_simultaneous();
        test_clip();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
